pll_rst_seq: RTL and testbench

//  Sequencer for the SB_PLL40_CORE wrapper. Runs on the PLL reference clock clk_in.
//  - Holds PLL RESETB low, releases it, waits for a debounced LOCK, then releases the system reset.
//  - Retries on lock timeout; falls back to BYPASS after MAX_RETRY failures.
//  - Re-sequences on lock loss or a software relock request.

---
 rtl/pll_seq_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_rst_seq.sv | 160 ++++++++++++++++
 tb/tb_pll_rst_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the SB_PLL40_CORE reset sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_WAIT = 2'd1,
      S_RUN  = 2'd2,
      S_FAIL = 2'd3
   } seq_state_t;

   localparam int unsigned DEF_RST_HOLD_CYC     = 16;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 256;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 4096;
   localparam int unsigned DEF_MAX_RETRY        = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to clk_i.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: non-blocking assignments so both flops sample their pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: holds RESETB, waits for a debounced LOCK, then releases
// the system reset; retries on timeout and falls back to BYPASS after MAX_RETRY.
module pll_rst_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
   input  logic       clk_in,
   input  logic       c_sys_rst_n,
   input  logic       pll_lock,
   input  logic       sw_relock,
   output logic       pll_resetb,
   output logic       pll_bypass,
   output logic       sys_rst_n,
   output logic [1:0] seq_state,
   output logic [2:0] retry_cnt,
   output logic       pll_fail
);

   localparam int unsigned RST_W = $clog2(RST_HOLD_CYC + 1);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYC + 1);
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT_CYC + 1);

   localparam logic [RST_W-1:0] RST_MAX   = RST_W'(RST_HOLD_CYC);
   localparam logic [RST_W-1:0] RST_END   = RST_W'(RST_HOLD_CYC - 1);
   localparam logic [STB_W-1:0] STB_MAX   = STB_W'(LOCK_STABLE_CYC);
   localparam logic [STB_W-1:0] STB_END   = STB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(LOCK_TIMEOUT_CYC);
   localparam logic [TMO_W-1:0] TMO_END   = TMO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

   seq_state_t       state_q;
   logic             pll_resetb_q;
   logic             pll_bypass_q;
   logic             sys_rst_n_q;
   logic             pll_fail_q;
   logic [2:0]       retry_cnt_q;

   logic [RST_W-1:0] rst_cnt_q,    rst_cnt_d;
   logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q,    tmo_cnt_d;

   logic lock_s;
   logic rst_done, stable_hit, tmo_hit, lock_lost, leave;

   // LOCK is meaningless while RESETB is low, so it is masked before synchronising;
   // every attempt then sees the full synchroniser latency after RESETB rises.
   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk_i   (clk_in),
      .rst_n_i (c_sys_rst_n),
      .d_i     (pll_lock & pll_resetb_q),
      .q_o     (lock_s)
   );

   assign rst_done   = (state_q == S_RST)  && (rst_cnt_q == RST_END);
   assign stable_hit = (state_q == S_WAIT) && lock_s && (stable_cnt_q == STB_END);
   assign tmo_hit    = (state_q == S_WAIT) && (tmo_cnt_q == TMO_END);
   assign lock_lost  = (state_q == S_RUN)  && !lock_s;
   assign leave      = sw_relock || rst_done || stable_hit || tmo_hit || lock_lost;

   always_comb begin
      // NOTE: hold values assigned up front so no path leaves a counter unassigned (no latch).
      rst_cnt_d    = rst_cnt_q;
      stable_cnt_d = stable_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      if (leave) begin
         rst_cnt_d    = '0;
         stable_cnt_d = '0;
         tmo_cnt_d    = '0;
      end else begin
         case (state_q)
            S_RST: begin
               if (rst_cnt_q != RST_MAX) rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            S_WAIT: begin
               if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               if (!lock_s)                      stable_cnt_d = '0;
               else if (stable_cnt_q != STB_MAX) stable_cnt_d = stable_cnt_q + STB_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge c_sys_rst_n) begin
      if (!c_sys_rst_n) begin
         rst_cnt_q    <= '0;
         stable_cnt_q <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         rst_cnt_q    <= rst_cnt_d;
         stable_cnt_q <= stable_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   always_ff @(posedge clk_in or negedge c_sys_rst_n) begin
      if (!c_sys_rst_n) begin
         state_q      <= S_RST;
         pll_resetb_q <= 1'b0;
         pll_bypass_q <= 1'b0;
         sys_rst_n_q  <= 1'b0;
         pll_fail_q   <= 1'b0;
         retry_cnt_q  <= '0;
      end else if (sw_relock) begin
         state_q      <= S_RST;
         pll_resetb_q <= 1'b0;
         pll_bypass_q <= 1'b0;
         sys_rst_n_q  <= 1'b0;
         pll_fail_q   <= 1'b0;
         retry_cnt_q  <= '0;
      end else begin
         case (state_q)
            S_RST: begin
               if (rst_done) begin
                  state_q      <= S_WAIT;
                  pll_resetb_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (stable_hit) begin
                  state_q <= S_RUN;
               end else if (tmo_hit) begin
                  pll_resetb_q <= 1'b0;
                  if (retry_cnt_q < RETRY_MAX) begin
                     state_q     <= S_RST;
                     retry_cnt_q <= retry_cnt_q + 3'd1;
                  end else begin
                     state_q      <= S_FAIL;
                     pll_bypass_q <= 1'b1;
                     sys_rst_n_q  <= 1'b1;
                     pll_fail_q   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (lock_lost) begin
                  state_q      <= S_RST;
                  pll_resetb_q <= 1'b0;
                  sys_rst_n_q  <= 1'b0;
               end else begin
                  sys_rst_n_q  <= 1'b1;
               end
            end
            default: ;  // FAIL holds until sw_relock or reset
         endcase
      end
   end

   assign pll_resetb = pll_resetb_q;
   assign pll_bypass = pll_bypass_q;
   assign sys_rst_n  = sys_rst_n_q;
   assign seq_state  = state_q;
   assign retry_cnt  = retry_cnt_q;
   assign pll_fail   = pll_fail_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small timing parameters and hand-computed cycle expectations.
module tb_pll_rst_seq;
   import pll_seq_pkg::*;

   localparam int unsigned RST_HOLD_CYC     = 4;
   localparam int unsigned LOCK_STABLE_CYC  = 8;
   localparam int unsigned LOCK_TIMEOUT_CYC = 32;
   localparam int unsigned MAX_RETRY        = 2;

   logic       clk_in = 1'b0;
   logic       c_sys_rst_n;
   logic       pll_lock;
   logic       sw_relock;
   logic       pll_resetb;
   logic       pll_bypass;
   logic       sys_rst_n;
   logic [1:0] seq_state;
   logic [2:0] retry_cnt;
   logic       pll_fail;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk_in = ~clk_in;

   pll_rst_seq #(
      .RST_HOLD_CYC     (RST_HOLD_CYC),
      .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
      .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
      .MAX_RETRY        (MAX_RETRY)
   ) dut (
      .clk_in      (clk_in),
      .c_sys_rst_n (c_sys_rst_n),
      .pll_lock    (pll_lock),
      .sw_relock   (sw_relock),
      .pll_resetb  (pll_resetb),
      .pll_bypass  (pll_bypass),
      .sys_rst_n   (sys_rst_n),
      .seq_state   (seq_state),
      .retry_cnt   (retry_cnt),
      .pll_fail    (pll_fail)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input seq_state_t st, input logic rb,
                             input logic byp, input logic sr, input logic [2:0] rc,
                             input logic fl);
      check({tag, ".state"},  32'(seq_state),  32'(st));
      check({tag, ".resetb"}, 32'(pll_resetb), 32'(rb));
      check({tag, ".bypass"}, 32'(pll_bypass), 32'(byp));
      check({tag, ".sysrst"}, 32'(sys_rst_n),  32'(sr));
      check({tag, ".retry"},  32'(retry_cnt),  32'(rc));
      check({tag, ".fail"},   32'(pll_fail),   32'(fl));
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   initial begin
      c_sys_rst_n = 1'b1;
      pll_lock    = 1'b1;
      sw_relock   = 1'b0;
      #2;
      c_sys_rst_n = 1'b0;
      #1;
      expect_out("reset", S_RST, 0, 0, 0, 3'd0, 0);
      step(2);
      expect_out("reset_hold", S_RST, 0, 0, 0, 3'd0, 0);

      // Scenario 1: lock high throughout; edges counted from reset release.
      c_sys_rst_n = 1'b1;
      step(3);
      expect_out("t1_c3", S_RST, 0, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t1_c4", S_WAIT, 1, 0, 0, 3'd0, 0);
      step(10);
      expect_out("t1_c14", S_RUN, 1, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t1_c15", S_RUN, 1, 0, 1, 3'd0, 0);

      // Scenario 3: one-cycle lock drop in RUN, then full re-lock.
      pll_lock = 1'b0;
      step(1);
      pll_lock = 1'b1;
      step(1);
      expect_out("t3_c2", S_RUN, 1, 0, 1, 3'd0, 0);
      step(1);
      expect_out("t3_c3", S_RST, 0, 0, 0, 3'd0, 0);
      step(3);
      expect_out("t3_hold", S_RST, 0, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t3_wait", S_WAIT, 1, 0, 0, 3'd0, 0);
      step(10);
      expect_out("t3_run", S_RUN, 1, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t3_sysrst", S_RUN, 1, 0, 1, 3'd0, 0);

      // Scenario 4: lock toggling with period 5 never debounces; first attempt times out.
      sw_relock = 1'b1;
      pll_lock  = 1'b0;
      step(1);
      sw_relock = 1'b0;
      expect_out("t4_relock", S_RST, 0, 0, 0, 3'd0, 0);
      for (int i = 1; i <= 35; i++) begin
         pll_lock = ((i % 5) < 3);
         step(1);
         check("t4_sysrst_low", 32'(sys_rst_n), 32'd0);
      end
      expect_out("t4_c35", S_WAIT, 1, 0, 0, 3'd0, 0);
      pll_lock = 1'b0;
      step(1);
      expect_out("t4_tmo1", S_RST, 0, 0, 0, 3'd1, 0);

      // Scenario 2: lock held low; second timeout retries, third enters FAIL.
      step(3);
      expect_out("t2_pulse1", S_RST, 0, 0, 0, 3'd1, 0);
      step(1);
      expect_out("t2_wait2", S_WAIT, 1, 0, 0, 3'd1, 0);
      step(31);
      expect_out("t2_pre_tmo2", S_WAIT, 1, 0, 0, 3'd1, 0);
      step(1);
      expect_out("t2_tmo2", S_RST, 0, 0, 0, 3'd2, 0);
      step(4);
      expect_out("t2_wait3", S_WAIT, 1, 0, 0, 3'd2, 0);
      step(31);
      expect_out("t2_pre_fail", S_WAIT, 1, 0, 0, 3'd2, 0);
      step(1);
      expect_out("t2_fail", S_FAIL, 0, 1, 1, 3'd2, 1);
      pll_lock = 1'b1;
      step(20);
      expect_out("t2_fail_hold", S_FAIL, 0, 1, 1, 3'd2, 1);

      // Scenario 5: sw_relock out of FAIL clears the sticky state and re-locks.
      sw_relock = 1'b1;
      step(1);
      sw_relock = 1'b0;
      expect_out("t5_relock", S_RST, 0, 0, 0, 3'd0, 0);
      step(14);
      expect_out("t5_run", S_RUN, 1, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t5_sysrst", S_RUN, 1, 0, 1, 3'd0, 0);

      // Stable lock completing on the very timeout cycle must win over the retry.
      sw_relock = 1'b1;
      pll_lock  = 1'b0;
      step(1);
      sw_relock = 1'b0;
      step(26);
      expect_out("tie_c26", S_WAIT, 1, 0, 0, 3'd0, 0);
      pll_lock = 1'b1;
      step(9);
      expect_out("tie_c35", S_WAIT, 1, 0, 0, 3'd0, 0);
      step(1);
      expect_out("tie_c36", S_RUN, 1, 0, 0, 3'd0, 0);
      step(1);
      expect_out("tie_c37", S_RUN, 1, 0, 1, 3'd0, 0);

      // Scenario 6: asynchronous reset mid-WAIT, between clock edges.
      sw_relock = 1'b1;
      step(1);
      sw_relock = 1'b0;
      step(6);
      expect_out("t6_wait", S_WAIT, 1, 0, 0, 3'd0, 0);
      #2;
      c_sys_rst_n = 1'b0;
      #1;
      expect_out("t6_async", S_RST, 0, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t6_held", S_RST, 0, 0, 0, 3'd0, 0);
      c_sys_rst_n = 1'b1;
      step(3);
      expect_out("t6_c3", S_RST, 0, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t6_c4", S_WAIT, 1, 0, 0, 3'd0, 0);
      step(10);
      expect_out("t6_c14", S_RUN, 1, 0, 0, 3'd0, 0);
      step(1);
      expect_out("t6_c15", S_RUN, 1, 0, 1, 3'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
